// File: rtl/mem_hazard_pkg.sv
// Shared types and defaults for the memory-hazard unit.
// Entry layout, ld/st opcode defaults and the occupancy-count width.
package mem_hazard_pkg;

  localparam int RD_MAX = 8;

  localparam logic [4:0] LD_OP_DEF = 5'b10001;
  localparam logic [4:0] ST_OP_DEF = 5'b10000;

  // rd is stored at RD_MAX bits; narrower specifiers are zero-extended
  typedef struct packed {
    logic              valid;
    logic              is_ld;
    logic              is_st;
    logic [RD_MAX-1:0] rd;
  } entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_op_decode.sv
// Opcode classifier for loads and stores.
// Pure combinational match against the configured opcodes.
module mem_op_decode
  import mem_hazard_pkg::*;
#(
  parameter int             OPW   = 5,
  parameter logic [OPW-1:0] LD_OP = LD_OP_DEF,
  parameter logic [OPW-1:0] ST_OP = ST_OP_DEF
) (
  input  logic [OPW-1:0] opcode,
  output logic           is_ld,
  output logic           is_st
);

  assign is_ld = (opcode == LD_OP);
  assign is_st = (opcode == ST_OP);

endmodule

// File: rtl/mem_hazard_unit.sv
// Tracks in-flight loads/stores after ID, detects load-use
// hazards and drives the IF/ID stall/bubble handshake.
module mem_hazard_unit
  import mem_hazard_pkg::*;
#(
  parameter int              OPW     = 5,
  parameter int              REGW    = 3,
  parameter int              DEPTH   = 4,
  parameter int              LU_DIST = 1,
  parameter logic [OPW-1:0]  ST_OP   = ST_OP_DEF,
  parameter logic [OPW-1:0]  LD_OP   = LD_OP_DEF,
  parameter int              CNTW    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [OPW-1:0]            in_opcode,
  input  logic [REGW-1:0]           in_rd,
  input  logic [REGW-1:0]           in_rs,
  input  logic [REGW-1:0]           in_rt,
  input  logic                      in_uses_rs,
  input  logic                      in_uses_rt,
  input  logic                      advance,
  input  logic                      flush,
  output logic                      in_ready,
  output logic                      load_use_stall,
  output logic                      mem_busy,
  output logic [cnt_w(DEPTH)-1:0]   mem_count,
  output logic [CNTW-1:0]           stall_cnt
);

  localparam int CW = cnt_w(DEPTH);

  entry_t            ent [DEPTH];
  logic              dec_ld;
  logic              dec_st;
  logic [DEPTH-1:0]  hit;
  logic [DEPTH-1:0]  memv;
  logic [CW-1:0]     acc [DEPTH+1];
  logic [RD_MAX-1:0] rd_x;
  logic [RD_MAX-1:0] rs_x;
  logic [RD_MAX-1:0] rt_x;

  assign rd_x = RD_MAX'(in_rd);
  assign rs_x = RD_MAX'(in_rs);
  assign rt_x = RD_MAX'(in_rt);

  mem_op_decode #(
    .OPW   (OPW),
    .LD_OP (LD_OP),
    .ST_OP (ST_OP)
  ) u_dec (
    .opcode (in_opcode),
    .is_ld  (dec_ld),
    .is_st  (dec_st)
  );

  assign acc[0] = '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign memv[i] = ent[i].valid
                   & (ent[i].is_ld | ent[i].is_st);
    assign acc[i+1] = acc[i] + CW'(memv[i]);
    // only the leading entries hold non-forwardable loads
    if (i < LU_DIST) begin : g_lu
      assign hit[i] = ent[i].valid & ent[i].is_ld
        & ((in_uses_rs & (ent[i].rd == rs_x))
         | (in_uses_rt & (ent[i].rd == rt_x)));
    end else begin : g_far
      assign hit[i] = 1'b0;
    end
  end

  assign load_use_stall = in_valid & (|hit);
  assign in_ready  = advance & ~load_use_stall & ~flush;
  assign mem_busy  = (in_valid & (dec_ld | dec_st)) | (|memv);
  assign mem_count = acc[DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
    end else if (advance) begin
      for (int i = 1; i < DEPTH; i++) ent[i] <= ent[i-1];
      ent[0] <= in_ready
        ? entry_t'{in_valid, dec_ld, dec_st, rd_x}
        : entry_t'('0);
      if (load_use_stall && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_mem_hazard_unit.sv
// Bench for mem_hazard_unit: default and swept instances
// compared against a queue-level model of the hazard rules.
module tb_mem_hazard_unit;

  localparam logic [4:0] LD  = 5'b10001;
  localparam logic [4:0] ST  = 5'b10000;
  localparam logic [4:0] ADD = 5'b00001;
  localparam logic [4:0] NOP = 5'b00000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_opcode = '0;
  logic [2:0] in_rd = '0, in_rs = '0, in_rt = '0;
  logic       in_uses_rs = 1'b0, in_uses_rt = 1'b0;
  logic       advance = 1'b0, flush = 1'b0;

  logic        rdy0, lus0, busy0;
  logic [2:0]  cnt0;
  logic [15:0] sc0;
  logic        rdy1, lus1, busy1;
  logic [2:0]  cnt1;
  logic [1:0]  sc1;

  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs),
    .in_rt(in_rt), .in_uses_rs(in_uses_rs),
    .in_uses_rt(in_uses_rt), .advance(advance), .flush(flush),
    .in_ready(rdy0), .load_use_stall(lus0), .mem_busy(busy0),
    .mem_count(cnt0), .stall_cnt(sc0)
  );

  mem_hazard_unit #(.DEPTH(6), .LU_DIST(2), .CNTW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs),
    .in_rt(in_rt), .in_uses_rs(in_uses_rs),
    .in_uses_rt(in_uses_rt), .advance(advance), .flush(flush),
    .in_ready(rdy1), .load_use_stall(lus1), .mem_busy(busy1),
    .mem_count(cnt1), .stall_cnt(sc1)
  );

  // reference model: per instance, an in-flight instruction list
  int D[2]    = '{4, 6};
  int L[2]    = '{1, 2};
  int SMAX[2] = '{65535, 3};
  bit mv[2][8], mld[2][8], mst[2][8];
  int mrd[2][8];
  int msc[2];

  function automatic bit e_stall(int k);
    if (!in_valid) return 0;
    for (int i = 0; i < L[k]; i++)
      if (mv[k][i] && mld[k][i] &&
          ((in_uses_rs && mrd[k][i] == int'(in_rs)) ||
           (in_uses_rt && mrd[k][i] == int'(in_rt))))
        return 1;
    return 0;
  endfunction

  function automatic int e_count(int k);
    int n = 0;
    for (int i = 0; i < D[k]; i++)
      if (mv[k][i] && (mld[k][i] || mst[k][i])) n++;
    return n;
  endfunction

  function automatic bit e_busy(int k);
    return (in_valid && (in_opcode == LD || in_opcode == ST))
           || e_count(k) > 0;
  endfunction

  function automatic bit e_ready(int k);
    return advance && !e_stall(k) && !flush;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit s, r;
      s = e_stall(k);
      r = e_ready(k);
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) mv[k][i] = 0;
        msc[k] = 0;
      end else if (flush) begin
        for (int i = 0; i < 8; i++) mv[k][i] = 0;
      end else if (advance) begin
        for (int i = D[k] - 1; i > 0; i--) begin
          mv[k][i]  = mv[k][i-1];
          mld[k][i] = mld[k][i-1];
          mst[k][i] = mst[k][i-1];
          mrd[k][i] = mrd[k][i-1];
        end
        mv[k][0]  = r && in_valid;
        mld[k][0] = in_opcode == LD;
        mst[k][0] = in_opcode == ST;
        mrd[k][0] = int'(in_rd);
        if (s && msc[k] < SMAX[k]) msc[k]++;
      end
    end
  end

  task automatic step(input bit v, input logic [4:0] op,
                      input int rd, input int rs, input int rt,
                      input bit urs, input bit urt,
                      input bit adv, input bit fl);
    @(negedge clk);
    in_valid = v; in_opcode = op;
    in_rd = 3'(rd); in_rs = 3'(rs); in_rt = 3'(rt);
    in_uses_rs = urs; in_uses_rt = urt;
    advance = adv; flush = fl;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; in_valid = 0; advance = 0; flush = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    step(1, LD, 1, 0, 0, 0, 0, 1, 0);
    step(1, ADD, 2, 1, 0, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, LD, 1, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (cnt0 !== 3'd4) begin
      errs++; $display("FAIL reset_fill cnt0=%0d want 4", cnt0);
    end
    do_reset();
    vectors++;
    if (cnt0 !== 3'd0 || cnt1 !== 3'd0) begin
      errs++;
      $display("FAIL reset_cnt cnt0=%0d cnt1=%0d want 0", cnt0, cnt1);
    end
    vectors++;
    if (sc0 !== 16'd0 || sc1 !== 2'd0) begin
      errs++; $display("FAIL reset_sc sc0=%0d sc1=%0d want 0", sc0, sc1);
    end
    in_valid = 1; in_opcode = ST; advance = 1; #1;
    vectors++;
    if (lus0 !== 1'b0 || rdy0 !== 1'b1 || busy0 !== 1'b1) begin
      errs++;
      $display("FAIL reset_out lus=%b rdy=%b busy=%b want 0 1 1",
               lus0, rdy0, busy0);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    step(1, LD, 2, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (rdy0 !== 1'b1 || lus0 !== 1'b0) begin
      errs++; $display("FAIL lu_ld rdy=%b lus=%b want 1 0", rdy0, lus0);
    end
    step(1, ADD, 3, 2, 0, 1, 0, 1, 0);
    vectors++;
    if (lus0 !== 1'b1 || rdy0 !== 1'b0 || sc0 !== 16'd0) begin
      errs++;
      $display("FAIL lu_stall lus=%b rdy=%b sc=%0d want 1 0 0",
               lus0, rdy0, sc0);
    end
    step(1, ADD, 3, 2, 0, 1, 0, 1, 0);
    vectors++;
    if (lus0 !== 1'b0 || rdy0 !== 1'b1 || sc0 !== 16'd1
        || cnt0 !== 3'd1) begin
      errs++;
      $display("FAIL lu_accept lus=%b rdy=%b sc=%0d cnt=%0d want 0 1 1 1",
               lus0, rdy0, sc0, cnt0);
    end
    step(0, NOP, 0, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (cnt0 !== 3'd1 || sc0 !== 16'd1) begin
      errs++;
      $display("FAIL lu_after cnt=%0d sc=%0d want 1 1", cnt0, sc0);
    end
  endtask

  task automatic test_no_false();
    do_reset();
    step(1, LD, 2, 0, 0, 0, 0, 1, 0);
    step(1, ADD, 6, 2, 3, 0, 1, 1, 0);
    vectors++;
    if (lus0 !== 1'b0 || rdy0 !== 1'b1 || lus1 !== 1'b0) begin
      errs++;
      $display("FAIL nf_unused lus0=%b rdy0=%b lus1=%b want 0 1 0",
               lus0, rdy0, lus1);
    end
    step(1, ST, 2, 4, 5, 1, 1, 1, 0);
    step(1, ADD, 7, 2, 2, 1, 1, 1, 0);
    vectors++;
    if (lus0 !== 1'b0 || lus1 !== 1'b0 || rdy1 !== 1'b1) begin
      errs++;
      $display("FAIL nf_store lus0=%b lus1=%b rdy1=%b want 0 0 1",
               lus0, lus1, rdy1);
    end
  endtask

  task automatic test_occupancy();
    int exp_c[9] = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
    logic [4:0] ops[4] = '{ST, LD, ST, LD};
    do_reset();
    for (int s = 0; s < 9; s++) begin
      if (s < 4) step(1, ops[s], s, 0, 0, 0, 0, 1, 0);
      else if (s < 8) step(1, NOP, 0, 0, 0, 0, 0, 1, 0);
      else step(0, NOP, 0, 0, 0, 0, 0, 1, 0);
      vectors++;
      if (int'(cnt0) != exp_c[s]) begin
        errs++;
        $display("FAIL occ_cnt step %0d cnt=%0d want %0d",
                 s, cnt0, exp_c[s]);
      end
    end
    vectors++;
    if (busy0 !== 1'b0) begin
      errs++; $display("FAIL occ_busy busy=%b want 0", busy0);
    end
  endtask

  task automatic test_freeze_flush();
    do_reset();
    step(1, LD, 5, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 3; c++) begin
      step(1, ADD, 1, 5, 0, 1, 0, 0, 0);
      vectors++;
      if (lus0 !== 1'b1 || rdy0 !== 1'b0 || sc0 !== 16'd0
          || cnt0 !== 3'd1) begin
        errs++;
        $display("FAIL freeze c%0d lus=%b rdy=%b sc=%0d cnt=%0d", c,
                 lus0, rdy0, sc0, cnt0);
      end
    end
    step(1, ADD, 1, 5, 0, 1, 0, 1, 1);
    vectors++;
    if (rdy0 !== 1'b0 || lus0 !== 1'b1) begin
      errs++; $display("FAIL flush_cyc rdy=%b lus=%b want 0 1", rdy0, lus0);
    end
    step(1, ADD, 1, 5, 0, 1, 0, 1, 0);
    vectors++;
    if (lus0 !== 1'b0 || cnt0 !== 3'd0 || sc0 !== 16'd0
        || rdy0 !== 1'b1) begin
      errs++;
      $display("FAIL flush_after lus=%b cnt=%0d sc=%0d rdy=%b want 0 0 0 1",
               lus0, cnt0, sc0, rdy0);
    end
  endtask

  task automatic test_sweep();
    bit want[3] = '{1, 1, 0};
    do_reset();
    for (int p = 0; p < 2; p++) begin
      step(1, LD, 4, 0, 0, 0, 0, 1, 0);
      for (int b = 0; b < 3; b++) begin
        step(1, ADD, 1, 4, 0, 1, 0, 1, 0);
        vectors++;
        if (lus1 !== want[b]) begin
          errs++;
          $display("FAIL sweep_stall p%0d b%0d lus1=%b want %b",
                   p, b, lus1, want[b]);
        end
      end
    end
    step(0, NOP, 0, 0, 0, 0, 0, 1, 0);
    vectors++;
    if (sc1 !== 2'd3 || sc0 !== 16'd2) begin
      errs++;
      $display("FAIL sweep_sat sc1=%0d sc0=%0d want 3 2", sc1, sc0);
    end
  endtask

  task automatic test_random();
    logic [4:0] pick[4] = '{LD, ST, ADD, NOP};
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst_n      = ($urandom_range(0, 49) != 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_opcode  = ($urandom_range(0, 7) == 0) ? 5'($urandom)
                                               : pick[$urandom_range(0, 3)];
      in_rd      = 3'($urandom_range(0, 3));
      in_rs      = 3'($urandom_range(0, 3));
      in_rt      = 3'($urandom_range(0, 3));
      in_uses_rs = 1'($urandom);
      in_uses_rt = 1'($urandom);
      advance    = ($urandom_range(0, 4) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      #1;
      vectors++;
      if (lus0 !== e_stall(0) || rdy0 !== e_ready(0)
          || busy0 !== e_busy(0)) begin
        errs++;
        $display("FAIL rnd0_comb n%0d lus/rdy/busy=%b%b%b want %b%b%b", n,
                 lus0, rdy0, busy0, e_stall(0), e_ready(0), e_busy(0));
      end
      vectors++;
      if (int'(cnt0) != e_count(0) || int'(sc0) != msc[0]) begin
        errs++;
        $display("FAIL rnd0_reg n%0d cnt=%0d sc=%0d want %0d %0d", n,
                 cnt0, sc0, e_count(0), msc[0]);
      end
      vectors++;
      if (lus1 !== e_stall(1) || rdy1 !== e_ready(1)
          || busy1 !== e_busy(1)) begin
        errs++;
        $display("FAIL rnd1_comb n%0d lus/rdy/busy=%b%b%b want %b%b%b", n,
                 lus1, rdy1, busy1, e_stall(1), e_ready(1), e_busy(1));
      end
      vectors++;
      if (int'(cnt1) != e_count(1) || int'(sc1) != msc[1]) begin
        errs++;
        $display("FAIL rnd1_reg n%0d cnt=%0d sc=%0d want %0d %0d", n,
                 cnt1, sc1, e_count(1), msc[1]);
      end
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false();
    test_occupancy();
    test_freeze_flush();
    test_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
